// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: upstream/downstream handshake bundle of the immediate generator.
// slave = the generator itself, master = the surrounding pipeline.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid,
        input  in_instr,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_imm,
        output out_fmt,
        output out_err,
        output out_tag
    );

    modport master (
        output in_valid,
        output in_instr,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_imm,
        input  out_fmt,
        input  out_err,
        input  out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder feeding a 2-entry in-order FIFO.
// Optional macro IMM_GEN_CSR_EN adds the Z (CSR zimm) format.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [31:0]     ins;
    logic [2:0]      dec_fmt;
    logic [31:0]     raw;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    assign ins = bus.in_instr;

    always_comb begin
        dec_fmt = FMT_NONE;
        unique case (ins[6:0])
            OP_IMM, OP_LOAD, OP_JALR: dec_fmt = FMT_I;
            OP_SYS: begin
`ifdef IMM_GEN_CSR_EN
                dec_fmt = ins[14] ? FMT_Z : FMT_I;
`else
                dec_fmt = FMT_I;
`endif
            end
            OP_STORE:        dec_fmt = FMT_S;
            OP_BR:           dec_fmt = FMT_B;
            OP_LUI, OP_AUIPC: dec_fmt = FMT_U;
            OP_JAL:          dec_fmt = FMT_J;
            default:         dec_fmt = FMT_NONE;
        endcase
    end

    // raw holds the 32-bit sign-extended form; widening to XLEN keeps the sign
    always_comb begin
        raw = '0;
        case (dec_fmt)
            FMT_I: raw = {{20{ins[31]}}, ins[31:20]};
            FMT_S: raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B: raw = {{19{ins[31]}}, ins[31], ins[7],
                          ins[30:25], ins[11:8], 1'b0};
            FMT_U: raw = {ins[31:12], 12'b0};
            FMT_J: raw = {{11{ins[31]}}, ins[31], ins[19:12],
                          ins[20], ins[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign dec_imm = (dec_fmt == FMT_Z) ? XLEN'(ins[19:15])
                                        : XLEN'(signed'(raw));
    assign dec_err = (dec_fmt == FMT_NONE);

    logic [XLEN-1:0]  imm_q [2];
    logic [2:0]       fmt_q [2];
    logic             err_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       cnt_q, cnt_d;
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic             push, pop;

    assign bus.in_ready  = (cnt_q < 2'd2) && !flush;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready && !flush;

    always_comb begin
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            cnt_d  = 2'd0;
            wptr_d = 1'b0;
            rptr_d = 1'b0;
        end else begin
            if (push) wptr_d = ~wptr_q;
            if (pop)  rptr_d = ~rptr_q;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= '0;
                err_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (push) begin
                imm_q[wptr_q] <= dec_imm;
                fmt_q[wptr_q] <= dec_fmt;
                err_q[wptr_q] <= dec_err;
                tag_q[wptr_q] <= bus.in_tag;
            end
        end
    end

    assign bus.out_imm = imm_q[rptr_q];
    assign bus.out_fmt = fmt_q[rptr_q];
    assign bus.out_err = err_q[rptr_q];
    assign bus.out_tag = tag_q[rptr_q];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives XLEN=32 and XLEN=64 instances with shared stimulus
// and compares both against an arithmetic reference model with a FIFO queue.
module tb_imm_gen_pipe;
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        err;
        logic [4:0]  tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;
    int          n_chk = 0;
    int          n_err = 0;
    ent_t        mq[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64();

    assign b32.in_valid  = in_valid;
    assign b32.in_instr  = in_instr;
    assign b32.in_tag    = in_tag;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_instr  = in_instr;
    assign b64.in_tag    = in_tag;
    assign b64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b32)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b64)
    );

    // immediate value computed as a signed integer from the field weights
    function automatic ent_t ref_dec(input logic [31:0] w, input logic [4:0] tg);
        ent_t   e;
        longint v;
        longint sgn;
        int     op;
        op = int'(w[6:0]);
        sgn = w[31] ? 64'sd1 : 64'sd0;
        e.tag = tg;
        e.err = 1'b0;
        v = 0;
        if (op == 'h13 || op == 'h03 || op == 'h67 || op == 'h73) e.fmt = 3'd1;
        else if (op == 'h23) e.fmt = 3'd2;
        else if (op == 'h63) e.fmt = 3'd3;
        else if (op == 'h37 || op == 'h17) e.fmt = 3'd4;
        else if (op == 'h6F) e.fmt = 3'd5;
        else e.fmt = 3'd0;
`ifdef IMM_GEN_CSR_EN
        if (op == 'h73 && w[14]) e.fmt = 3'd6;
`endif
        case (e.fmt)
            3'd1: v = longint'(w[30:20]) - sgn * 2048;
            3'd2: v = longint'(w[30:25]) * 32 + longint'(w[11:7]) - sgn * 2048;
            3'd3: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                      + longint'(w[11:8]) * 2 - sgn * 4096;
            3'd4: v = longint'(w[30:12]) * 4096 - sgn * 64'sd2147483648;
            3'd5: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                      + longint'(w[30:21]) * 2 - sgn * 1048576;
            3'd6: v = longint'(w[19:15]);
            default: begin v = 0; e.err = 1'b1; end
        endcase
        e.imm = 64'(v);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w,
                         input logic [4:0] tg, input logic ordy,
                         input logic fl);
        in_valid  = v;
        in_instr  = w;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
    endtask

    // advance one cycle and update the model with the pre-edge inputs
    task automatic tick();
        bit rdy, pu, po;
        @(posedge clk);
        rdy = (mq.size() < 2) && !flush;
        pu  = in_valid && rdy;
        po  = (mq.size() != 0) && out_ready && !flush;
        if (rst || flush) mq.delete();
        else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(ref_dec(in_instr, in_tag));
        end
        @(negedge clk);
    endtask

    task automatic clear();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_chk++; if (b32.out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid: got %b want 0", b32.out_valid); end
        n_chk++; if (b32.out_imm !== 32'h0) begin n_err++;
            $display("FAIL reset_imm32: got %h want 0", b32.out_imm); end
        n_chk++; if (b64.out_imm !== 64'h0) begin n_err++;
            $display("FAIL reset_imm64: got %h want 0", b64.out_imm); end
        n_chk++; if (b32.out_fmt !== 3'd0 || b32.out_err !== 1'b0) begin n_err++;
            $display("FAIL reset_fmt_err: got %0d/%b want 0/0", b32.out_fmt, b32.out_err); end
        n_chk++; if (b32.out_tag !== 5'd0) begin n_err++;
            $display("FAIL reset_tag: got %0d want 0", b32.out_tag); end
        n_chk++; if (b32.in_ready !== 1'b1 || b64.in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_in_ready: got %b/%b want 1", b32.in_ready, b64.in_ready); end
    endtask

    task automatic test_addi();
        clear();
        drive(1'b1, 32'hFFF00093, 5'd3, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (b32.out_valid !== 1'b1) begin n_err++;
            $display("FAIL addi_valid: got %b want 1", b32.out_valid); end
        n_chk++; if (b32.out_imm !== 32'hFFFFFFFF) begin n_err++;
            $display("FAIL addi_imm: got %h want ffffffff", b32.out_imm); end
        n_chk++; if (b32.out_fmt !== 3'd1 || b32.out_err !== 1'b0) begin n_err++;
            $display("FAIL addi_fmt: got %0d/%b want 1/0", b32.out_fmt, b32.out_err); end
        n_chk++; if (b32.out_tag !== 5'd3) begin n_err++;
            $display("FAIL addi_tag: got %0d want 3", b32.out_tag); end
    endtask

    task automatic test_xlen64();
        clear();
        drive(1'b1, 32'h800000B7, 5'd1, 1'b0, 1'b0);
        tick();
        in_instr = 32'hFE000EE3;
        in_tag   = 5'd2;
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (b64.out_imm !== 64'hFFFFFFFF80000000 || b64.out_fmt !== 3'd4) begin
            n_err++; $display("FAIL lui64: got %h/%0d want ffffffff80000000/4",
                              b64.out_imm, b64.out_fmt); end
        n_chk++; if (b32.out_imm !== 32'h80000000) begin n_err++;
            $display("FAIL lui32: got %h want 80000000", b32.out_imm); end
        n_chk++; if (b32.in_ready !== 1'b0) begin n_err++;
            $display("FAIL full_in_ready: got %b want 0", b32.in_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_chk++; if (b64.out_imm !== 64'hFFFFFFFFFFFFFFFC || b64.out_fmt !== 3'd3) begin
            n_err++; $display("FAIL beq64: got %h/%0d want fffffffffffffffc/3",
                              b64.out_imm, b64.out_fmt); end
        n_chk++; if (b32.out_imm !== 32'hFFFFFFFC || b32.out_tag !== 5'd2) begin
            n_err++; $display("FAIL beq32: got %h/%0d want fffffffc/2",
                              b32.out_imm, b32.out_tag); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ws[3];
        logic [4:0]  ts[3];
        int          idx, got;
        bit          acc;
        ent_t        e;
        ws[0] = 32'h00500113; ts[0] = 5'd1;
        ws[1] = 32'h00112423; ts[1] = 5'd2;
        ws[2] = 32'h123450B7; ts[2] = 5'd3;
        clear();
        idx = 0;
        got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, ws[idx], ts[idx], 1'b0, 1'b0);
            #1;
            if (c == 2) begin
                n_chk++; if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin
                    n_err++; $display("FAIL b2b_hold: got rdy=%b vld=%b want 0/1",
                                      b32.in_ready, b32.out_valid); end
            end
            acc = mq.size() < 2;
            tick();
            if (acc) idx++;
        end
        for (int c = 0; c < 12 && got < 3; c++) begin
            drive(idx < 3, ws[idx % 3], ts[idx % 3], 1'b1, 1'b0);
            #1;
            if (b32.out_valid === 1'b1) begin
                e = ref_dec(ws[got], ts[got]);
                n_chk++; if (b32.out_tag !== ts[got] || b64.out_imm !== e.imm) begin
                    n_err++; $display("FAIL b2b_order%0d: got tag=%0d imm=%h want %0d/%h",
                                      got, b32.out_tag, b64.out_imm, ts[got], e.imm); end
                got++;
            end
            acc = (idx < 3) && (mq.size() < 2);
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_chk++; if (got != 3) begin n_err++;
            $display("FAIL b2b_drain: got %0d entries want 3", got); end
    endtask

    task automatic test_flush();
        clear();
        drive(1'b1, 32'h00A00093, 5'd5, 1'b0, 1'b0);
        tick();
        in_tag = 5'd6;
        tick();
        drive(1'b1, 32'h00B00093, 5'd7, 1'b1, 1'b1);
        #1;
        n_chk++; if (b32.in_ready !== 1'b0) begin n_err++;
            $display("FAIL flush_in_ready: got %b want 0", b32.in_ready); end
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        n_chk++; if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin n_err++;
            $display("FAIL flush_valid: got %b/%b want 0", b32.out_valid, b64.out_valid); end
        n_chk++; if (b32.in_ready !== 1'b1) begin n_err++;
            $display("FAIL flush_ready_after: got %b want 1", b32.in_ready); end
        drive(1'b1, 32'h01400093, 5'd9, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (b32.out_tag !== 5'd9 || b32.out_imm !== 32'd20) begin n_err++;
            $display("FAIL flush_refill: got tag=%0d imm=%h want 9/14",
                     b32.out_tag, b32.out_imm); end
    endtask

    task automatic test_err_csr();
        clear();
        drive(1'b1, 32'hABCDE07F, 5'd7, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0007D073, 5'd8, 1'b1, 1'b0);
        #1;
        n_chk++; if (b32.out_err !== 1'b1 || b32.out_fmt !== 3'd0) begin n_err++;
            $display("FAIL none_fmt: got err=%b fmt=%0d want 1/0", b32.out_err, b32.out_fmt); end
        n_chk++; if (b64.out_imm !== 64'h0 || b32.out_imm !== 32'h0) begin n_err++;
            $display("FAIL none_imm: got %h/%h want 0", b64.out_imm, b32.out_imm); end
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
`ifdef IMM_GEN_CSR_EN
        n_chk++; if (b64.out_imm !== 64'd15 || b64.out_fmt !== 3'd6) begin n_err++;
            $display("FAIL csrwi: got %h/%0d want f/6", b64.out_imm, b64.out_fmt); end
`else
        n_chk++; if (b64.out_imm !== 64'd0 || b64.out_fmt !== 3'd1) begin n_err++;
            $display("FAIL csrwi: got %h/%0d want 0/1", b64.out_imm, b64.out_fmt); end
`endif
        n_chk++; if (b32.out_tag !== 5'd8 || b32.out_err !== 1'b0) begin n_err++;
            $display("FAIL csrwi_tag: got %0d/%b want 8/0", b32.out_tag, b32.out_err); end
    endtask

    task automatic test_rst_mid();
        clear();
        drive(1'b1, 32'hFFF00093, 5'd4, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h800000B7, 5'd5, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        n_chk++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin n_err++;
            $display("FAIL rstmid_hs: got vld=%b rdy=%b want 0/1", b32.out_valid, b32.in_ready); end
        n_chk++; if (b32.out_imm !== 32'h0 || b64.out_imm !== 64'h0) begin n_err++;
            $display("FAIL rstmid_imm: got %h/%h want 0", b32.out_imm, b64.out_imm); end
        n_chk++; if (b64.out_fmt !== 3'd0 || b64.out_err !== 1'b0 || b64.out_tag !== 5'd0) begin
            n_err++; $display("FAIL rstmid_fields: got %0d/%b/%0d want 0/0/0",
                              b64.out_fmt, b64.out_err, b64.out_tag); end
    endtask

    task automatic test_random();
        logic [6:0]  ops[10];
        logic [31:0] w;
        bit          er;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
        clear();
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(9, 0) != 9) w[6:0] = ops[$urandom_range(8, 0)];
            drive($urandom_range(9, 0) < 7, w, 5'($urandom), $urandom_range(9, 0) < 6,
                  $urandom_range(15, 0) == 0);
            rst = ($urandom_range(79, 0) == 0);
            #1;
            er = 1'b0;
            if (b32.in_ready !== ((mq.size() < 2) && !flush)) er = 1'b1;
            if (b64.out_valid !== (mq.size() != 0)) er = 1'b1;
            if (mq.size() != 0) begin
                if (b32.out_imm !== mq[0].imm[31:0] || b64.out_imm !== mq[0].imm) er = 1'b1;
                if (b32.out_fmt !== mq[0].fmt || b64.out_err !== mq[0].err) er = 1'b1;
                if (b64.out_tag !== mq[0].tag) er = 1'b1;
            end
            n_chk++;
            if (er) begin
                n_err++;
                $display("FAIL rand%0d: got rdy=%b vld=%b imm=%h fmt=%0d tag=%0d, model size=%0d",
                         i, b32.in_ready, b64.out_valid, b64.out_imm, b64.out_fmt,
                         b64.out_tag, mq.size());
                if (mq.size() != 0)
                    $display("  want imm=%h fmt=%0d err=%b tag=%0d",
                             mq[0].imm, mq[0].fmt, mq[0].err, mq[0].tag);
            end
            tick();
            rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_xlen64();
        test_back_to_back();
        test_flush();
        test_err_csr();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
